// File: rtl/tns_enc_21_seq.sv
// Multi-cycle greedy Tribonacci-numeral-system encoder: `BLEN07-bit binary word -> 21-bit TNS codeword.
// Resolves STEPS_PER_CYCLE code bits per clock, MSB first, with valid/ready handshakes on both sides.
`ifndef TNS_VH
`define TNS_VH
`define BLEN07  19
`define TNS01_C 1
`define TNS01_B 2
`define TNS01_A 4
`define TNS02_C 7
`define TNS02_B 13
`define TNS02_A 24
`define TNS03_C 44
`define TNS03_B 81
`define TNS03_A 149
`define TNS04_C 274
`define TNS04_B 504
`define TNS04_A 927
`define TNS05_C 1705
`define TNS05_B 3136
`define TNS05_A 5768
`define TNS06_C 10609
`define TNS06_B 19513
`define TNS06_A 35890
`define TNS07_C 66012
`define TNS07_B 121415
`define TNS07_A 223317
`endif

module tns_enc_21_seq #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [`BLEN07-1:0]  datain,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [20:0]         codeout,
  output logic                err
);

  localparam int unsigned RW = `BLEN07 + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [RW-1:0] weight(input logic [4:0] k);
    case (k)
      5'd20:   weight = RW'(`TNS07_A);
      5'd19:   weight = RW'(`TNS07_B);
      5'd18:   weight = RW'(`TNS07_C);
      5'd17:   weight = RW'(`TNS06_A);
      5'd16:   weight = RW'(`TNS06_B);
      5'd15:   weight = RW'(`TNS06_C);
      5'd14:   weight = RW'(`TNS05_A);
      5'd13:   weight = RW'(`TNS05_B);
      5'd12:   weight = RW'(`TNS05_C);
      5'd11:   weight = RW'(`TNS04_A);
      5'd10:   weight = RW'(`TNS04_B);
      5'd9:    weight = RW'(`TNS04_C);
      5'd8:    weight = RW'(`TNS03_A);
      5'd7:    weight = RW'(`TNS03_B);
      5'd6:    weight = RW'(`TNS03_C);
      5'd5:    weight = RW'(`TNS02_A);
      5'd4:    weight = RW'(`TNS02_B);
      5'd3:    weight = RW'(`TNS02_C);
      5'd2:    weight = RW'(`TNS01_A);
      5'd1:    weight = RW'(`TNS01_B);
      default: weight = RW'(`TNS01_C);
    endcase
  endfunction

  function automatic logic [RW-1:0] weight_sum();
    logic [RW-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 21; i++) acc = acc + weight(5'(i));
    return acc;
  endfunction

  localparam logic [RW-1:0] TNS_SUM = weight_sum();

  if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 3) begin : g_bad_steps
    $error("tns_enc_21_seq: STEPS_PER_CYCLE must be 1 or 3");
  end

  state_t        state;
  logic [RW-1:0] rem;
  logic [4:0]    idx;

  logic [RW-1:0] step_rem;
  logic [20:0]   step_code;
  logic [4:0]    k;
  logic          last;

  // Chained greedy subtraction over bits idx .. idx-STEPS_PER_CYCLE+1 within one cycle.
  always_comb begin
    step_rem  = rem;
    step_code = codeout;
    k         = idx;
    for (int unsigned s = 0; s < STEPS_PER_CYCLE; s++) begin
      k = idx - 5'(s);
      if (step_rem >= weight(k)) begin
        step_code[k] = 1'b1;
        step_rem     = step_rem - weight(k);
      end else begin
        step_code[k] = 1'b0;
      end
    end
  end

  assign last = (idx < 5'(STEPS_PER_CYCLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      codeout   <= '0;
      err       <= 1'b0;
      rem       <= '0;
      idx       <= 5'd20;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            codeout  <= '0;
            idx      <= 5'd20;
            in_ready <= 1'b0;
            if ({2'b00, datain} > TNS_SUM) begin
              err       <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              rem   <= {2'b00, datain};
              err   <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          codeout <= step_code;
          rem     <= step_rem;
          if (last) begin
            out_valid <= 1'b1;
            state     <= DONE;
            assert (step_rem == '0)
              else $error("tns_enc_21_seq: nonzero remainder at end of RUN");
          end else begin
            idx <= idx - 5'(STEPS_PER_CYCLE);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tns_enc_21_seq.sv
// Directed and random checks of tns_enc_21_seq with STEPS_PER_CYCLE=1 and =3 side by side.
`ifndef BLEN07
`define BLEN07 19
`endif

module tb_tns_enc_21_seq;

  localparam int unsigned BW      = `BLEN07;
  localparam int unsigned TNS_SUM = 489395;
  localparam int unsigned TW [21] = '{1, 2, 4, 7, 13, 24, 44, 81, 149, 274, 504, 927,
                                      1705, 3136, 5768, 10609, 19513, 35890, 66012,
                                      121415, 223317};

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [BW-1:0] datain    [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [20:0]   codeout   [2];
  logic          err       [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tns_enc_21_seq #(.STEPS_PER_CYCLE(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .datain(datain[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .codeout(codeout[0]), .err(err[0])
  );

  tns_enc_21_seq #(.STEPS_PER_CYCLE(3)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .datain(datain[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .codeout(codeout[1]), .err(err[1])
  );

  function automatic int unsigned ncyc(input int d);
    return (d == 0) ? 21 : 7;
  endfunction

  function automatic int unsigned dec(input logic [20:0] code);
    int unsigned acc = 0;
    for (int i = 0; i < 21; i++) if (code[i]) acc += TW[i];
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        failures++;
        $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
  endtask

  task automatic xfer(input int d, input logic [BW-1:0] data, input int bp,
                      output logic [20:0] code, output logic e, output int lat);
    int n = 0;
    while (!in_ready[d] && n < 200) begin @(posedge clk); #1; n++; end
    chk($sformatf("in_ready_wait[%0d]", d), 32'(in_ready[d]), 32'd1);
    datain[d]   = data;
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    datain[d]   = BW'($urandom);
    lat = 1;
    while (!out_valid[d] && lat < 60) begin @(posedge clk); #1; lat++; end
    code = codeout[d];
    e    = err[d];
    for (int i = 0; i < bp; i++) begin @(posedge clk); #1; end
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    chk($sformatf("out_valid_drop[%0d]", d), 32'(out_valid[d]), 32'd0);
  endtask

  initial begin
    logic [20:0] code;
    logic        e;
    int          lat;
    logic [BW-1:0] vdat [9];
    logic [20:0]   vcode[9];
    logic          verr [9];

    vdat = '{19'd0, 19'd1, 19'd100, 19'd1000, 19'd223317, 19'd223316,
             19'd489395, 19'd489396, 19'd524287};
    vcode = '{21'h000000, 21'h000001, 21'h000096, 21'h000865, 21'h100000, 21'h0DB6DB,
              21'h1FFFFF, 21'h000000, 21'h000000};
    verr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; datain[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_in_ready[%0d]", d),  32'(in_ready[d]),  32'd1);
      chk($sformatf("rst_out_valid[%0d]", d), 32'(out_valid[d]), 32'd0);
      chk($sformatf("rst_codeout[%0d]", d),   32'(codeout[d]),   32'd0);
      chk($sformatf("rst_err[%0d]", d),       32'(err[d]),       32'd0);
    end
    rst = 1'b0;

    // Directed vectors, including 0, TNS_SUM, TNS_SUM+1 and single-weight words
    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < 9; v++) begin
        xfer(d, vdat[v], v % 3, code, e, lat);
        chk($sformatf("code[%0d] d=%0d", d, vdat[v]), 32'(code), 32'(vcode[v]));
        chk($sformatf("err[%0d] d=%0d", d, vdat[v]),  32'(e),    32'(verr[v]));
        chk($sformatf("lat[%0d] d=%0d", d, vdat[v]),  32'(lat),
            verr[v] ? 32'd1 : 32'(ncyc(d) + 1));
        if (!verr[v])
          chk($sformatf("roundtrip[%0d] d=%0d", d, vdat[v]), 32'(dec(code)), 32'(vdat[v]));
      end
    end

    // Reset held 3 cycles while both encoders are mid-RUN
    for (int d = 0; d < 2; d++) begin datain[d] = 19'd1000; in_valid[d] = 1'b1; end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst_in_ready[%0d]", d),  32'(in_ready[d]),  32'd1);
      chk($sformatf("midrst_out_valid[%0d]", d), 32'(out_valid[d]), 32'd0);
      chk($sformatf("midrst_codeout[%0d]", d),   32'(codeout[d]),   32'd0);
      chk($sformatf("midrst_err[%0d]", d),       32'(err[d]),       32'd0);
      xfer(d, 19'd100, 0, code, e, lat);
      chk($sformatf("postrst_code[%0d]", d), 32'(code), 32'h96);
    end

    // Back-pressure in DONE with upstream holding the next word
    datain[0] = 19'd1000; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("bp_reach_done", 32'(out_valid[0]), 32'd1);
    datain[0] = 19'd100; in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_codeout",   32'(codeout[0]),   32'h865);
      chk("bp_err",       32'(err[0]),       32'd0);
      chk("bp_in_ready",  32'(in_ready[0]),  32'd0);
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("bp_idle_in_ready",  32'(in_ready[0]),  32'd1);
    chk("bp_idle_out_valid", 32'(out_valid[0]), 32'd0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("bp_accept2", 32'(in_ready[0]), 32'd0);
    lat = 0;
    while (!out_valid[0] && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("bp_word2_code", 32'(codeout[0]), 32'h96);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("nodup_out_valid", 32'(out_valid[0]), 32'd0);
      chk("nodup_in_ready",  32'(in_ready[0]),  32'd1);
    end

    // Random in-range words with random back-pressure, decoded by the bench's own weights
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 200; n++) begin
        logic [BW-1:0] w;
        w = BW'($urandom_range(0, TNS_SUM));
        xfer(d, w, int'($urandom_range(0, 3)), code, e, lat);
        chk($sformatf("rand_rt[%0d] d=%0d", d, w), 32'(dec(code)), 32'(w));
        chk($sformatf("rand_err[%0d] d=%0d", d, w), 32'(e), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
